// File: rtl/shift_pkg.sv
// Shared types for the pipelined bidirectional barrel shifter.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_LOG = 2'b00,
    SH_ARI = 2'b01,
    SH_ROT = 2'b10,
    SH_RSV = 2'b11
  } shift_mode_t;

  // Width-independent part of the stage payload; each stage wraps it with data and amount.
  typedef struct packed {
    logic        left;
    shift_mode_t mode;
    logic        sign;
    logic        carry;
  } shift_ctrl_t;

  function automatic logic sign_fill(input shift_ctrl_t c);
    return c.sign && !c.left && (c.mode == SH_ARI);
  endfunction

endpackage

// File: rtl/shift_lr_stage.sv
// One pipeline slice: applies its share of the rotate levels, then registers valid + payload.
module shift_lr_stage
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int IDX    = 0,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              up_valid,
  input  logic [WIDTH-1:0]  up_data,
  input  logic [SW-1:0]     up_amount,
  input  shift_ctrl_t       up_ctrl,
  output logic              valid,
  output logic [WIDTH-1:0]  data,
  output logic [SW-1:0]     amount,
  output shift_ctrl_t       ctrl
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SW-1:0]    amount;
    shift_ctrl_t      ctrl;
  } payload_t;

  payload_t nxt;
  payload_t q;

  // Stages only rotate; zero/sign fill is applied once at the pipeline output.
  always_comb begin
    nxt.data   = up_data;
    nxt.amount = up_amount;
    nxt.ctrl   = up_ctrl;
    for (int k = 0; k < SW; k++) begin
      if (((k * STAGES) / SW == IDX) && up_amount[k]) begin
        if (up_ctrl.left)
          nxt.data = (nxt.data << (1 << k)) | (nxt.data >> (WIDTH - (1 << k)));
        else
          nxt.data = (nxt.data >> (1 << k)) | (nxt.data << (WIDTH - (1 << k)));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= up_valid;
      q     <= nxt;
    end
  end

  assign data   = q.data;
  assign amount = q.amount;
  assign ctrl   = q.ctrl;

endmodule

// File: rtl/shift_lr_pipe.sv
// Pipelined bidirectional barrel shifter with rotate, carry-out and valid/ready backpressure.
module shift_lr_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [SW-1:0]    s,
  input  logic             left,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout
);

  logic [STAGES-1:0] stg_v;
  logic [STAGES-1:0] stg_load;
  logic [WIDTH-1:0]  stg_d [STAGES];
  logic [SW-1:0]     stg_a [STAGES];
  shift_ctrl_t       stg_c [STAGES];

  shift_ctrl_t       in_ctrl;
  logic [SW-1:0]     carry_idx;
  logic [WIDTH-1:0]  keep_mask;
  logic              down;

  // For shifts and rotates alike the carry is x[WIDTH-s] (left) or x[s-1] (right).
  always_comb begin
    carry_idx     = left ? (SW'(0) - s) : (s - SW'(1));
    in_ctrl.left  = left;
    in_ctrl.mode  = shift_mode_t'(mode);
    in_ctrl.sign  = x[WIDTH-1];
    in_ctrl.carry = (s != '0) && x[carry_idx];
  end

  always_comb begin
    stg_load = '0;
    down     = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      stg_load[i] = !stg_v[i] || down;
      down        = stg_load[i];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    logic [SW-1:0]    up_a;
    shift_ctrl_t      up_c;

    if (i == 0) begin : g_src
      assign up_v = in_valid;
      assign up_d = x;
      assign up_a = s;
      assign up_c = in_ctrl;
    end else begin : g_src
      assign up_v = stg_v[i-1];
      assign up_d = stg_d[i-1];
      assign up_a = stg_a[i-1];
      assign up_c = stg_c[i-1];
    end

    shift_lr_stage #(
      .WIDTH (WIDTH),
      .STAGES(STAGES),
      .IDX   (i)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (stg_load[i]),
      .up_valid (up_v),
      .up_data  (up_d),
      .up_amount(up_a),
      .up_ctrl  (up_c),
      .valid    (stg_v[i]),
      .data     (stg_d[i]),
      .amount   (stg_a[i]),
      .ctrl     (stg_c[i])
    );
  end

  // Shifts clear the vacated bits of the rotated word and optionally refill them with the sign.
  always_comb begin
    keep_mask = '1;
    if (stg_c[STAGES-1].mode != SH_ROT)
      keep_mask = stg_c[STAGES-1].left ? ({WIDTH{1'b1}} << stg_a[STAGES-1])
                                       : ({WIDTH{1'b1}} >> stg_a[STAGES-1]);
    z = (stg_d[STAGES-1] & keep_mask) | (sign_fill(stg_c[STAGES-1]) ? ~keep_mask : '0);
  end

  assign cout      = stg_c[STAGES-1].carry;
  assign out_valid = stg_v[STAGES-1];
  assign in_ready  = stg_load[0];

endmodule

// File: tb/tb_shift_lr_pipe.sv
// Self-checking bench: directed cases, backpressure, reset-in-flight and random traffic vs a reference model.
module tb_shift_lr_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [4:0]  s;
  logic        left;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z;
  logic        cout;

  typedef struct {
    logic [31:0] z;
    logic        c;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur_exp;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_out = 0;
  logic        accepted;
  logic        hold_armed = 1'b0;
  logic [31:0] held_z;
  logic        held_c;

  shift_lr_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .s(s), .left(left), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .z(z), .cout(cout)
  );

  always #5 clk = ~clk;

  // Reference: plain wide arithmetic on the operand, one case per mode family.
  function automatic exp_t refModel(input logic [31:0] xx, input int unsigned ss,
                                    input logic ll, input logic [1:0] mm);
    exp_t               r;
    logic [63:0]        wide;
    logic signed [63:0] swide;
    if (ss == 0) begin
      r.z = xx;
      r.c = 1'b0;
    end else if (mm == 2'b10) begin
      if (ll) begin
        r.z = (xx << ss) | (xx >> (32 - ss));
        r.c = r.z[0];
      end else begin
        r.z = (xx >> ss) | (xx << (32 - ss));
        r.c = r.z[31];
      end
    end else if (ll) begin
      wide = {32'h0, xx} << ss;
      r.z  = wide[31:0];
      r.c  = wide[32];
    end else begin
      if (mm == 2'b01) begin
        swide = {xx, 32'h0};
        swide = swide >>> ss;
        wide  = swide;
      end else begin
        wide = {xx, 32'h0} >> ss;
      end
      r.z = wide[63:32];
      r.c = wide[31];
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] xx, input int unsigned ss,
                               input logic ll, input logic [1:0] mm);
    in_valid = v;
    x        = xx;
    s        = ss[4:0];
    left     = ll;
    mode     = mm;
    cur_exp  = refModel(xx, ss, ll, mm);
  endtask

  task automatic applyRandom();
    applyStimulus(1'b1, $urandom, $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)));
  endtask

  // One clock: observe mid-cycle, score handshakes, then advance to just after the edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    accepted = in_valid && in_ready;
    if (hold_armed) begin
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_z", z, held_z);
      checkOutput("hold_cout", 32'(cout), 32'(held_c));
    end
    hold_armed = out_valid && !out_ready;
    held_z     = z;
    held_c     = cout;
    if (out_valid && exp_q.size() == 0) begin
      checkOutput("stale_valid", 32'(out_valid), 32'd0);
    end else if (out_valid && out_ready) begin
      e = exp_q.pop_front();
      checkOutput("z", z, e.z);
      checkOutput("cout", 32'(cout), 32'(e.c));
      n_out++;
    end
    if (accepted) exp_q.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic runDirected(input string tag, input logic [31:0] xx, input int unsigned ss,
                             input logic ll, input logic [1:0] mm,
                             input logic [31:0] ez, input logic ec);
    out_ready = 1'b1;
    applyStimulus(1'b1, xx, ss, ll, mm);
    cur_exp.z = ez;
    cur_exp.c = ec;
    accepted  = 1'b0;
    for (int t = 0; t < 10 && !accepted; t++) cycle();
    checkOutput({tag, "_accept"}, 32'(accepted), 32'd1);
    in_valid = 1'b0;
    checkOutput({tag, "_lat1"}, 32'(out_valid), 32'd0);
    cycle();
    checkOutput({tag, "_lat2"}, 32'(out_valid), 32'd1);
    cycle();
    checkOutput({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int sent;
    int n0;

    rst_n     = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, 32'h0, 0, 1'b0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_z", z, 32'h0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] directed cases");
    runDirected("lsl1",     32'h8000_0001, 1, 1'b1, 2'b00, 32'h0000_0002, 1'b1);
    runDirected("asr4",     32'hF000_0000, 4, 1'b0, 2'b01, 32'hFF00_0000, 1'b0);
    runDirected("lsr4",     32'hF000_0000, 4, 1'b0, 2'b00, 32'h0F00_0000, 1'b0);
    runDirected("ror1",     32'h0000_0001, 1, 1'b0, 2'b10, 32'h8000_0000, 1'b1);
    runDirected("rol8",     32'h1234_5678, 8, 1'b1, 2'b10, 32'h3456_7812, 1'b0);
    runDirected("s0_log",   32'hDEAD_BEEF, 0, 1'b0, 2'b00, 32'hDEAD_BEEF, 1'b0);
    runDirected("s0_ari",   32'hDEAD_BEEF, 0, 1'b1, 2'b01, 32'hDEAD_BEEF, 1'b0);
    runDirected("s0_rot",   32'hDEAD_BEEF, 0, 1'b0, 2'b10, 32'hDEAD_BEEF, 1'b0);
    runDirected("s0_rsv",   32'hDEAD_BEEF, 0, 1'b1, 2'b11, 32'hDEAD_BEEF, 1'b0);
    runDirected("rsv_r4",   32'hDEAD_BEEF, 4, 1'b0, 2'b11, 32'h0DEA_DBEE, 1'b1);
    runDirected("asl31",    32'h0000_0003, 31, 1'b1, 2'b01, 32'h8000_0000, 1'b1);
    runDirected("asr31",    32'h8000_0000, 31, 1'b0, 2'b01, 32'hFFFF_FFFF, 1'b0);

    $display("[TB] backpressure");
    n0        = n_out;
    sent      = 0;
    out_ready = 1'b0;
    applyRandom();
    for (int c = 0; c < 60 && (sent < 6 || exp_q.size() > 0); c++) begin
      out_ready = (c >= 5);
      if (c == 2) checkOutput("bp_sent", 32'(sent), 32'd2);
      if (c >= 2 && c < 5) checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      cycle();
      if (accepted) begin
        sent++;
        if (sent < 6) applyRandom();
        else in_valid = 1'b0;
      end
    end
    checkOutput("bp_count", 32'(n_out - n0), 32'd6);
    checkOutput("bp_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] reset with operations in flight");
    out_ready = 1'b0;
    applyRandom();
    cycle();
    applyRandom();
    cycle();
    in_valid = 1'b0;
    checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_z", z, 32'h0);
    exp_q.delete();
    hold_armed = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    runDirected("post_rst", 32'h0000_00F0, 4, 1'b0, 2'b00, 32'h0000_000F, 1'b0);

    $display("[TB] random traffic");
    n0 = n_out;
    sent = 0;
    applyRandom();
    for (int c = 0; c < 200; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (accepted) sent++;
      if (accepted || !in_valid) begin
        applyRandom();
        in_valid = ($urandom_range(0, 2) != 0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) cycle();
    checkOutput("rnd_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("rnd_count", 32'(n_out - n0), 32'(sent));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_lr_pipe.md
# shift_lr_pipe

Parametrised, pipelined bidirectional barrel shifter. It is the successor to the 32-bit combinational shifter in the functional unit. It adds a configurable word width, a configurable number of register stages, a rotate mode, a carry-out bit, and a valid/ready handshake with full backpressure. It sits between the operand-read stage and the result bus of the functional unit.

## Interface
Parameters:
- `WIDTH`, 32, data width; must be a power of two, ≥ 8.
- `STAGES`, 2, number of register stages; 1 ≤ `STAGES` ≤ log2(`WIDTH`).
- `SW`, $clog2(`WIDTH`), shift-amount width; derived, not overridden.

Ports:
- `clk`  in  1  clock; one clock domain; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  an input operation is presented.
- `in_ready`  out  1  the block accepts an operation this cycle.
- `x`  in  `WIDTH`  operand.
- `s`  in  `SW`  shift amount, 0..`WIDTH`-1.
- `left`  in  1  1 = shift/rotate left, 0 = right.
- `mode`  in  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (executes as logical).
- `out_valid`  out  1  a result is presented.
- `out_ready`  in  1  downstream accepts the result.
- `z`  out  `WIDTH`  result.
- `cout`  out  1  last bit shifted out (see Operation).

## Operation
- Logical left: `z` = `x` << `s`, zero fill. Arithmetic left is identical to logical left.
- Logical right: zero fill from the MSB.
- Arithmetic right: fill with `x[WIDTH-1]`, sampled at acceptance.
- Rotate: bits leaving one end re-enter at the other end.
- `cout` for shifts:
  - left: `x[WIDTH-s]`
  - right: `x[s-1]`
- `cout` for rotate:
  - left: `z[0]`
  - right: `z[WIDTH-1]`
- `s` = 0 in any mode: `z` = `x`, `cout` = 0.
- The log2(`WIDTH`) shift levels (level k shifts by 2^k) are split across the stages: level k is placed in stage floor(k·`STAGES`/log2(`WIDTH`)).
- Each stage register carries:
  - partial data
  - the remaining amount bits
  - `left`, `mode`, the sign bit
  - a valid flag
- The carry is computed from the accepted `x` and `s` at stage 0 and travels with its operation.
- Pipeline handshake:
  - A stage loads when it is empty, or when its downstream stage (or the output, via `out_ready`) consumes this cycle.
  - `in_ready` = stage 0 loads this cycle.
  - Bubbles collapse.
  - Capacity is `STAGES` operations.
- Ordering: results leave in acceptance order. Nothing is dropped or duplicated.
- While `out_valid`=1 and `out_ready`=0, `z` and `cout` hold stable.
- `out_valid` stays high until the result is consumed.

## Timing
- Latency: `STAGES` cycles from acceptance (`in_valid` & `in_ready` at edge N) to `out_valid`=1 after edge N+`STAGES`.
- Throughput: one operation per cycle while `out_ready`=1.
- `in_ready` is combinational from `out_ready` and the stage valid flags. There is no combinational path from `x`, `s`, `mode` or `left` to any output.
- Reset values (`rst_n`=0): all stage valid flags 0, `out_valid`=0, `z`=0, `cout`=0, and `in_ready`=1 once reset is released.
- Reset asserted mid-operation: all in-flight operations are discarded immediately and asynchronously. `out_valid` drops in the same cycle.
- Simultaneous output consume and input accept when full: both occur in that cycle, and occupancy is unchanged.
- `in_valid`=0: the pipeline drains normally. Invalid stages never assert `out_valid`.

## Structure
- Package `shift_pkg`:
  - `shift_mode_t` enum: `SH_LOG`, `SH_ARI`, `SH_ROT`, `SH_RSV`.
  - the stage payload struct: data, amount, `left`, mode, sign, carry.
- Sub-module `shift_lr_stage`:
  - one register slice holding valid + payload;
  - applies its assigned shift levels combinationally before the register;
  - instantiated `STAGES` times via generate.
- The top level holds the input carry computation, the final fill/mask of the output and the ready chain.

## Test plan
(`WIDTH`=32, `STAGES`=2)
- `x`=0x8000_0001, `s`=1, left, logical → `z`=0x0000_0002, `cout`=1, `out_valid` two cycles after acceptance.
- `x`=0xF000_0000, `s`=4, right, arithmetic → `z`=0xFF00_0000, `cout`=0. Same operand, logical → `z`=0x0F00_0000.
- `x`=0x0000_0001, `s`=1, right, rotate → `z`=0x8000_0000, `cout`=1. `x`=0x1234_5678, `s`=8, left, rotate → `z`=0x3456_7812.
- `s`=0 in each of the four modes with `x`=0xDEAD_BEEF → `z`=0xDEAD_BEEF, `cout`=0. `mode`=11 with `s`=4, right → `z`=0x0DEA_DBEE.
- Backpressure: stream 6 operations back-to-back and hold `out_ready`=0 for 5 cycles → `in_ready` falls after 2 acceptances, `z` holds stable, all 6 results emerge in order, no loss.
- Assert `rst_n`=0 with 2 operations in flight → `out_valid`=0 immediately. After release, a new operation completes with 2-cycle latency and no stale result appears.
